// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: architectural width, special encodings and
// the fetch FSM state type.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- bubble inserted into IF/ID on flush or idle
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  // ebreak -- fetch stops once this is latched into IF/ID
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter: holds the fetch PC, adds 4 on advance, and takes a
// redirect target when the request is word aligned.
module pc_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_req,
  input  logic            advance,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc,
  output logic            target_misaligned
);

  logic [XLEN-1:0] pc_d, pc_q;
  logic            redirect;

  // Alignment is judged on the target alone so the controller can use it
  // without forming a loop through the request.
  assign target_misaligned = (target[1:0] != 2'b00);
  assign redirect          = redirect_req && !target_misaligned;
  assign pc                = pc_q;

  // Next PC: redirect wins over sequential advance; otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = target;
    end else if (advance) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the ROM address from the PC, latches
// the returned word into the IF/ID register and sequences IDLE/RUN/HALT.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int          TAM_POSICIONES = 1024,
  parameter int          TAM_PALABRA    = 32,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              STALL,
  input  logic                              BRANCH_TAKEN,
  input  logic [31:0]                       BRANCH_TARGET,
  input  logic [TAM_PALABRA-1:0]            INSTRUCTION_IN,
  output logic                              READ_EN,
  output logic [$clog2(TAM_POSICIONES)-1:0] INS_ADDRESS,
  output logic [31:0]                       PC_IF,
  output logic [31:0]                       PC_ID,
  output logic [TAM_PALABRA-1:0]            INSTR_ID,
  output logic                              VALID_ID,
  output logic                              HALTED,
  output logic                              MISALIGN_ERR
);

  localparam int AW = $clog2(TAM_POSICIONES);
  // One past the last ROM byte address, widened so the compare cannot wrap.
  localparam logic [XLEN:0] PC_LIMIT = {1'b0, 32'(TAM_POSICIONES)} << 2;
  localparam logic [TAM_PALABRA-1:0] NOP_W    = TAM_PALABRA'(NOP_INSTR);
  localparam logic [TAM_PALABRA-1:0] EBREAK_W = TAM_PALABRA'(EBREAK_INSTR);

  fetch_state_t           state_d, state_q;
  logic [31:0]            pc_id_d, pc_id_q;
  logic [TAM_PALABRA-1:0] instr_d, instr_q;
  logic                   valid_d, valid_q;
  logic                   mis_d, mis_q;
  logic                   branch_req, advance, target_misaligned, in_range;
  logic [31:0]            pc_if;

  pc_unit #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk              (CLK),
    .rst              (RESET),
    .redirect_req     (branch_req),
    .advance          (advance),
    .target           (BRANCH_TARGET),
    .pc               (pc_if),
    .target_misaligned(target_misaligned)
  );

  assign in_range     = ({1'b0, pc_if} < PC_LIMIT);
  assign INS_ADDRESS  = pc_if[AW+1:2];
  assign READ_EN      = (state_q == RUN) && in_range;
  assign PC_IF        = pc_if;
  assign PC_ID        = pc_id_q;
  assign INSTR_ID     = instr_q;
  assign VALID_ID     = valid_q;
  assign HALTED       = (state_q == HALT);
  assign MISALIGN_ERR = mis_q;

  // Next-state and IF/ID update; in RUN a redirect beats a stall, which
  // beats the end-of-ROM check and normal advance.
  always_comb begin
    state_d    = state_q;
    pc_id_d    = pc_id_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    mis_d      = mis_q;
    branch_req = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        valid_d = 1'b0;
        instr_d = NOP_W;
      end
      RUN: begin
        if (BRANCH_TAKEN) begin
          branch_req = 1'b1;
          valid_d    = 1'b0;
          instr_d    = NOP_W;
          if (target_misaligned) begin
            mis_d   = 1'b1;
            state_d = HALT;
          end
        end else if (STALL) begin
          // everything holds
        end else if (!in_range) begin
          valid_d = 1'b0;
          instr_d = NOP_W;
          state_d = HALT;
        end else begin
          advance = 1'b1;
          pc_id_d = pc_if;
          instr_d = INSTRUCTION_IN;
          valid_d = 1'b1;
          if (INSTRUCTION_IN == EBREAK_W) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
        instr_d = NOP_W;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and IF/ID register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      pc_id_q <= 32'h0;
      instr_q <= NOP_W;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_id_q <= pc_id_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

endmodule
